// File: rtl/util_axis_uart_packer.sv
// Packs the byte stream from util_axis_uart's receive port into bus_width-byte
// little-endian AXI-Stream words, flushing partial words on idle timeout or delimiter.
module util_axis_uart_packer #(
  parameter int         bus_width      = 4,
  parameter int         timeout_cycles = 1000,
  parameter bit         delim_ena      = 1'b0,
  parameter logic [7:0] delim_char     = 8'h0D
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [bus_width*8-1:0] m_axis_tdata,
  output logic [bus_width-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [0:0]             dbg_state_o
);

  localparam int CW = $clog2(bus_width + 1);
  localparam int TW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_V = TW'(timeout_cycles);
  localparam logic [CW-1:0] LAST_LANE = CW'(bus_width - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [bus_width*8-1:0] data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [bus_width*8-1:0] m_data_q, m_data_d;
  logic [bus_width-1:0]   m_keep_q, m_keep_d;
  logic                   m_last_q, m_last_d;
  logic                   m_valid_q, m_valid_d;

  logic                   done;
  logic                   accept;
  logic                   xfer;
  logic [bus_width-1:0]   keep_w;

  // Handshakes: a beat moves on a rising edge where valid & ready are both high;
  // valid never depends combinationally on ready on either port.
  assign done          = (state_q == ST_PEND);
  assign s_axis_tready = arstn & ~done;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign xfer          = done & (~m_valid_q | m_axis_tready);

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_valid_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    keep_w = '0;
    for (int i = 0; i < bus_width; i++) begin
      keep_w[i] = (CW'(i) < cnt_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    timer_d   = timer_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;

    if (xfer) begin
      // Unused lanes are already zero because the accumulator clears per word.
      m_data_d  = data_q;
      m_keep_d  = keep_w;
      m_last_d  = last_q;
      m_valid_d = 1'b1;
      data_d    = '0;
      cnt_d     = '0;
      last_d    = 1'b0;
      timer_d   = '0;
      state_d   = ST_FILL;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < bus_width; i++) begin
        if (cnt_q == CW'(i)) data_d[i*8 +: 8] = s_axis_tdata;
      end
      cnt_d   = cnt_q + 1'b1;
      timer_d = '0;
      if (cnt_q == LAST_LANE) begin
        state_d = ST_PEND;
        last_d  = 1'b0;
      end
      if (delim_ena && (s_axis_tdata == delim_char)) begin
        state_d = ST_PEND;
        last_d  = 1'b1;
      end
    end else if ((timeout_cycles > 0) && !done && (cnt_q != '0)) begin
      if (timer_q == TIMEOUT_V) begin
        state_d = ST_PEND;
        last_d  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= ST_FILL;
      data_q    <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_util_axis_uart_packer.sv
// Directed bench for util_axis_uart_packer: one instance with a short timeout and
// CR delimiter, one with default parameters fed at UART byte spacing.
module tb_util_axis_uart_packer;

  localparam int W = 37;  // {tlast, tkeep[3:0], tdata[31:0]}

  logic        aclk;
  logic        arstn;

  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [0:0]  dbg_state;

  logic [7:0]  s2_tdata;
  logic        s2_tvalid;
  logic        s2_tready;
  logic [31:0] m2_tdata;
  logic [3:0]  m2_tkeep;
  logic        m2_tlast;
  logic        m2_tvalid;
  logic        m2_tready;
  logic [0:0]  dbg2_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  int n_vec;
  int n_err;
  int beats2;

  util_axis_uart_packer #(
    .bus_width(4), .timeout_cycles(16), .delim_ena(1'b1), .delim_char(8'h0D)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .dbg_state_o(dbg_state)
  );

  util_axis_uart_packer dut2 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tlast(m2_tlast),
    .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .dbg_state_o(dbg2_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboards, sampled mid-cycle so the next rising edge completes the handshake
  always @(negedge aclk) begin
    if (arstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("unexp_beat", 64'({1'b1, m_tlast, m_tkeep, m_tdata}), 64'd0);
      else check("beat", 64'({m_tlast, m_tkeep, m_tdata}), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge aclk) begin
    if (arstn && m2_tvalid && m2_tready) begin
      beats2++;
      if (exp2_q.size() == 0) check("unexp_beat2", 64'({1'b1, m2_tlast, m2_tkeep, m2_tdata}), 64'd0);
      else check("beat2", 64'({m2_tlast, m2_tkeep, m2_tdata}), 64'(exp2_q.pop_front()));
    end
  end

  // drivers
  task automatic offer(input bit sel, input logic [7:0] b, input int bound, output bit ok);
    ok = 1'b0;
    if (sel) begin s2_tdata = b; s2_tvalid = 1'b1; end
    else begin s_tdata = b; s_tvalid = 1'b1; end
    for (int k = 0; k < bound; k++) begin
      @(negedge aclk);
      if (sel ? s2_tready : s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge aclk);
      #1;
    end
    if (sel) s2_tvalid = 1'b0;
    else s_tvalid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    offer(1'b0, b, 50, ok);
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    bit ok;
    bit early;
    int accepted;
    n_vec = 0; n_err = 0; beats2 = 0;
    arstn = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    s2_tdata = '0; s2_tvalid = 1'b0; m2_tready = 1'b1;

    // reset values
    idle(3);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_sready", 64'(s_tready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    arstn = 1'b1;
    idle(2);
    check("post_rst_sready", 64'(s_tready), 64'd1);

    // back-to-back full words
    exp_q.push_back({1'b0, 4'hF, 32'h44434241});
    exp_q.push_back({1'b0, 4'hF, 32'h48474645});
    for (int i = 0; i < 8; i++) send(8'h41 + 8'(i));
    idle(5);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // idle-timeout flush of a partial word
    exp_q.push_back({1'b1, 4'h3, 32'h00004241});
    send(8'h41);
    send(8'h42);
    early = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge aclk); #1;
      if (m_tvalid) early = 1'b1;
    end
    check("t2_no_early", 64'(early), 64'd0);
    check("t2_pend_state", 64'(dbg_state), 64'd1);
    @(posedge aclk); #1;
    check("t2_valid", 64'(m_tvalid), 64'd1);
    idle(3);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // delimiter closes a word immediately
    exp_q.push_back({1'b1, 4'h3, 32'h00000D41});
    send(8'h41);
    send(8'h0D);
    check("t3_lat0", 64'(m_tvalid), 64'd0);
    @(posedge aclk); #1;
    check("t3_lat1", 64'(m_tvalid), 64'd1);
    idle(3);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // full word closed by delimiter
    exp_q.push_back({1'b1, 4'hF, 32'h0D333231});
    send(8'h31); send(8'h32); send(8'h33); send(8'h0D);
    idle(3);
    check("t3b_drained", 64'(exp_q.size()), 64'd0);

    // backpressure: two words buffered, then stall
    m_tready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      offer(1'b0, 8'(i), 20, ok);
      if (!ok) break;
      accepted++;
    end
    check("t4_accepted", 64'(accepted), 64'd8);
    check("t4_sready_low", 64'(s_tready), 64'd0);
    check("t4_hold_valid", 64'(m_tvalid), 64'd1);
    check("t4_hold_data", 64'({m_tlast, m_tkeep, m_tdata}), 64'({1'b0, 4'hF, 32'h03020100}));
    exp_q.push_back({1'b0, 4'hF, 32'h03020100});
    exp_q.push_back({1'b0, 4'hF, 32'h07060504});
    exp_q.push_back({1'b0, 4'hF, 32'h0B0A0908});
    m_tready = 1'b1;
    for (int i = 8; i < 12; i++) send(8'(i));
    idle(5);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-word discards it
    send(8'h11);
    send(8'h22);
    idle(5);
    arstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk); #1;
      check("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("t5_rst_out", 64'({m_tlast, m_tkeep, m_tdata}), 64'd0);
      check("t5_rst_sready", 64'(s_tready), 64'd0);
    end
    arstn = 1'b1;
    idle(40);
    check("t5_no_flush", 64'(m_tvalid), 64'd0);
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    idle(5);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // default instance at UART byte spacing (125 aclk per character)
    exp2_q.push_back({1'b0, 4'hF, 32'h44434241});
    exp2_q.push_back({1'b0, 4'hF, 32'h48474645});
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 8'h41 + 8'(i), 50, ok);
      check("t6_accept", 64'(ok), 64'd1);
      idle(124);
    end
    idle(1500);
    check("t6_beats", 64'(beats2), 64'd2);
    check("t6_drained", 64'(exp2_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
